// File: rtl/shift_normalizer_if.sv
// shift_normalizer_if
// Handshake bundle for the shift normaliser.
//   A, ctl1   : operand and direction (1 = right / trailing zeros, 0 = left / leading zeros)
//   in_valid  : operand offered          in_ready  : normaliser can accept
//   out       : normalised operand       count     : positions shifted (0..WIDTH)
//   zero      : operand was zero         out_valid : result valid, held until out_ready
//   out_ready : consumer takes the result
// Modport slave is the normaliser side, master the producer/consumer side.
interface shift_normalizer_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
);
  logic [WIDTH-1:0] A;
  logic             ctl1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    count;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  A, ctl1, in_valid, out_ready,
    output in_ready, out, count, zero, out_valid
  );

  modport master (
    output A, ctl1, in_valid, out_ready,
    input  in_ready, out, count, zero, out_valid
  );
endinterface

// File: rtl/shift_normalizer.sv
// shift_normalizer
// Multi-cycle inverse of the ALU barrel shifter. Finds the shift amount that
// normalises operand A (left: leading zeros out, out[31]=1; right: trailing
// zeros out, out[0]=1) using a 5-stage binary search, one stage per clock.
// Ports:
//   clk   : single rising-edge clock
//   reset : synchronous, active-high; discards any in-flight operation
//   bus   : shift_normalizer_if.slave (A, ctl1, in_valid/in_ready,
//           out, count, zero, out_valid/out_ready)
// Optional feature macro: NORM_EARLY_EXIT_EN
//   defined   -> RUN ends as soon as W[31] is set; a zero operand skips RUN.
//   undefined -> fixed latency: out_valid rises 6 clocks after accept.
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  shift_normalizer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] w_reg, w_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [2:0]       k_reg, k_next;
  logic             zero_r_reg, zero_r_next;
  logic             ctl1_r_reg, ctl1_r_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             zero_out_reg, zero_out_next;
  logic             out_valid_reg, out_valid_next;

  logic [WIDTH-1:0] rev_a, rev_w;
  logic [CW-1:0]    step;
  logic [WIDTH-1:0] hi_mask;
  logic             stage_hit;
  logic [WIDTH-1:0] w_stage;
  logic [CW-1:0]    cnt_stage;

  // Right mode is a left search on the bit-reversed word, reversed back at the end.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign rev_a[gi] = bus.A[WIDTH-1-gi];
      assign rev_w[gi] = w_reg[WIDTH-1-gi];
    end
  endgenerate

  // Current stage examines the top 2^k bits of W.
  assign step      = CW'(1) << k_reg;
  assign hi_mask   = ~({WIDTH{1'b1}} >> step);
  assign stage_hit = ((w_reg & hi_mask) == '0);
  assign w_stage   = stage_hit ? (w_reg << step) : w_reg;
  assign cnt_stage = stage_hit ? (cnt_reg + step) : cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      w_reg         <= '0;
      cnt_reg       <= '0;
      k_reg         <= '0;
      zero_r_reg    <= 1'b0;
      ctl1_r_reg    <= 1'b0;
      out_reg       <= '0;
      count_reg     <= '0;
      zero_out_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      w_reg         <= w_next;
      cnt_reg       <= cnt_next;
      k_reg         <= k_next;
      zero_r_reg    <= zero_r_next;
      ctl1_r_reg    <= ctl1_r_next;
      out_reg       <= out_next;
      count_reg     <= count_next;
      zero_out_reg  <= zero_out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    w_next         = w_reg;
    cnt_next       = cnt_reg;
    k_next         = k_reg;
    zero_r_next    = zero_r_reg;
    ctl1_r_next    = ctl1_r_reg;
    out_next       = out_reg;
    count_next     = count_reg;
    zero_out_next  = zero_out_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone means accept.
        if (bus.in_valid) begin
          w_next      = bus.ctl1 ? rev_a : bus.A;
          cnt_next    = '0;
          zero_r_next = (bus.A == '0);
          ctl1_r_next = bus.ctl1;
          k_next      = 3'd4;
          state_next  = RUN;
`ifdef NORM_EARLY_EXIT_EN
          if (bus.A == '0) state_next = DONE;
`endif
        end
      end
      RUN: begin
        w_next   = w_stage;
        cnt_next = cnt_stage;
        k_next   = k_reg - 3'd1;
        if (k_reg == 3'd0) state_next = DONE;
`ifdef NORM_EARLY_EXIT_EN
        // Once the MSB is set no later stage can shift, so stop here.
        if (w_stage[WIDTH-1]) state_next = DONE;
`endif
      end
      DONE: begin
        // First DONE cycle captures the result; it is then held until taken.
        if (!out_valid_reg) begin
          out_next       = ctl1_r_reg ? rev_w : w_reg;
          count_next     = zero_r_reg ? CW'(WIDTH) : cnt_reg;
          zero_out_next  = zero_r_reg;
          out_valid_next = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out       = out_reg;
  assign bus.count     = count_reg;
  assign bus.zero      = zero_out_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;

  logic clk;
  logic reset;
  int   cyc;
  int   passed;
  int   total;

  shift_normalizer_if bus ();

  shift_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] out;
    logic [5:0]  count;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  localparam int EXP_LAT = 6;

  logic [31:0] dir_a [0:6] = '{32'h00010000, 32'h00000F00, 32'h00000000, 32'h00000000,
                               32'h80000000, 32'h00000001, 32'h00F0F000};
  logic        dir_c [0:6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  // Reference: plain linear scan for the first set bit from the chosen end.
  function automatic exp_t model(input logic [31:0] a, input logic c);
    exp_t e;
    int n;
    n = 0;
    if (a == 32'h0) begin
      e.out = 32'h0; e.count = 6'd32; e.zero = 1'b1;
      return e;
    end
    if (!c) begin
      while (a[31-n] == 1'b0) n++;
      e.out = a << n;
    end else begin
      while (a[n] == 1'b0) n++;
      e.out = a >> n;
    end
    e.count = 6'(n);
    e.zero  = 1'b0;
    return e;
  endfunction

  // Offer one operand; returns the cycle number right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic c, output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    bus.A = a; bus.ctl1 = c; bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        ok = 1'b1;
        sb.push_back(model(a, c));
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; does not complete the handshake.
  task automatic wait_out(output logic [31:0] o, output logic [5:0] cnt, output logic z,
                          output int vcyc, output bit to);
    to = 1'b1; o = '0; cnt = '0; z = 1'b0; vcyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        o = bus.out; cnt = bus.count; z = bus.zero; vcyc = cyc; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out !== 32'h0) $display("FAIL reset_out got %h want 00000000", bus.out); else passed++;
    total++; if (bus.count !== 6'd0) $display("FAIL reset_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.zero !== 1'b0) $display("FAIL reset_zero got %b want 0", bus.zero); else passed++;
    $display("reset: in_ready=%b out_valid=%b out=%h count=%0d zero=%b",
             bus.in_ready, bus.out_valid, bus.out, bus.count, bus.zero);
  endtask

  task automatic test_directed();
    int acc, vcyc; bit ok, to;
    logic [31:0] o; logic [5:0] cnt; logic z; exp_t e;
    for (int i = 0; i < 7; i++) begin
      send(dir_a[i], dir_c[i], acc, ok);
      total++; if (!ok) $display("FAIL dir_accept[%0d] got no accept want accept", i); else passed++;
      wait_out(o, cnt, z, vcyc, to);
      total++; if (to) $display("FAIL dir_timeout[%0d] got no out_valid want out_valid", i); else passed++;
      e = sb.pop_front();
      total++;
      if (o !== e.out || cnt !== e.count || z !== e.zero)
        $display("FAIL dir_result[%0d] got out=%h count=%0d zero=%b want out=%h count=%0d zero=%b",
                 i, o, cnt, z, e.out, e.count, e.zero);
      else passed++;
`ifndef NORM_EARLY_EXIT_EN
      total++; if (vcyc - acc !== EXP_LAT) $display("FAIL dir_latency[%0d] got %0d want %0d", i, vcyc - acc, EXP_LAT); else passed++;
`endif
      $display("directed: A=%h ctl1=%b -> out=%h count=%0d zero=%b lat=%0d",
               dir_a[i], dir_c[i], o, cnt, z, vcyc - acc);
      ack();
      total++; if (bus.out_valid !== 1'b0) $display("FAIL dir_valid_drop[%0d] got %b want 0", i, bus.out_valid); else passed++;
    end
  endtask

  task automatic test_backpressure();
    int acc, vcyc; bit ok, to;
    logic [31:0] o; logic [5:0] cnt; logic z; exp_t e;
    send(32'h00400000, 1'b0, acc, ok);
    @(posedge clk); #1;
    // Intruding operand while busy must be dropped.
    bus.A = 32'h0000FFFF; bus.ctl1 = 1'b0; bus.in_valid = 1'b1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_run got %b want 0", bus.in_ready); else passed++;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_run2 got %b want 0", bus.in_ready); else passed++;
    bus.in_valid = 1'b0;
    bus.A = 32'h12345678;
    wait_out(o, cnt, z, vcyc, to);
    total++; if (to) $display("FAIL bp_timeout got no out_valid want out_valid"); else passed++;
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out !== e.out || bus.count !== e.count || bus.zero !== e.zero)
        $display("FAIL bp_hold[%0d] got v=%b out=%h count=%0d want v=1 out=%h count=%0d",
                 i, bus.out_valid, bus.out, bus.count, e.out, e.count);
      else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_done[%0d] got %b want 0", i, bus.in_ready); else passed++;
      @(posedge clk); #1;
    end
    $display("backpressure: out=%h count=%0d held 3 cycles", bus.out, bus.count);
    ack();
    repeat (8) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_ignored_op got out_valid=%b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_reset_midrun();
    int acc, vcyc; bit ok, to;
    logic [31:0] o; logic [5:0] cnt; logic z; exp_t e;
    send(32'h00000300, 1'b0, acc, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(sb.pop_back());
    total++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.count !== 6'd0) $display("FAIL midrst_count got %0d want 0", bus.count); else passed++;
    $display("reset mid-run: in_ready=%b out_valid=%b count=%0d", bus.in_ready, bus.out_valid, bus.count);
    send(32'h00000700, 1'b1, acc, ok);
    wait_out(o, cnt, z, vcyc, to);
    e = sb.pop_front();
    total++;
    if (to || o !== e.out || cnt !== e.count || z !== e.zero)
      $display("FAIL midrst_next_op got out=%h count=%0d zero=%b want out=%h count=%0d zero=%b",
               o, cnt, z, e.out, e.count, e.zero);
    else passed++;
    $display("after reset: A=00000700 ctl1=1 -> out=%h count=%0d", o, cnt);
    ack();
  endtask

  task automatic test_back_to_back();
    int acc, vcyc; bit ok, to;
    logic [31:0] o, a; logic [5:0] cnt; logic z; logic c; exp_t e;
    for (int i = 0; i < 10; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      c = 1'($urandom_range(0, 1));
      if (c) a = a << $urandom_range(0, 31);
      send(a, c, acc, ok);
      wait_out(o, cnt, z, vcyc, to);
      e = sb.pop_front();
      total++;
      if (!ok || to || o !== e.out || cnt !== e.count || z !== e.zero)
        $display("FAIL b2b[%0d] A=%h ctl1=%b got out=%h count=%0d zero=%b want out=%h count=%0d zero=%b",
                 i, a, c, o, cnt, z, e.out, e.count, e.zero);
      else passed++;
      $display("b2b: A=%h ctl1=%b -> out=%h count=%0d zero=%b", a, c, o, cnt, z);
      ack();
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset = 1'b1;
    bus.A = '0; bus.ctl1 = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
